// File: rtl/fifo_pkg.sv
// Purpose: shared sizing constants for the single-clock FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default data/address widths and a depth helper so the top and the
// storage sub-module agree on the entry count.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 5;

  // Number of entries addressed by an aw-bit index.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

endpackage

// File: rtl/fifo_sync_mem.sv
// Purpose: storage array for fifo_sync, one write port and one registered read port.
// Latency: read data appears the edge after a qualified read; write lands at the edge.
// Backpressure: none here; the parent only asserts we/re for accepted requests.
//
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset (read register only)
//   we/waddr/wdat - qualified write strobe, address, data
//   re/raddr      - qualified read strobe, address
//   rdat          - registered read data, holds when re is low
import fifo_pkg::*;

module fifo_sync_mem #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdat,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdat
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // The array itself has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdat <= '0;
    end else if (re) begin
      rdat <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Purpose: single-clock FIFO, 2^ADDR_WIDTH entries, registered read port, full/empty flags.
// Latency: write visible (empty low) 1 cycle after accept; read data 1 cycle after accept.
// Backpressure: writes while full are dropped, reads while empty are ignored (data_out holds).
//
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   wr_en, data_in - write request and data
//   rd_en          - read request
//   data_out       - registered head word from the last accepted read
//   full, empty    - status flags, decoded from the registered pointers only
import fifo_pkg::*;

module fifo_sync #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Extra MSB is a wrap bit that tells full apart from empty when the
  // address bits match.
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                wr_acc;
  logic                rd_acc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  // Requests are qualified by the flags as they stand before the edge, so a
  // simultaneous read+write at full/empty only lets one side through. Reset
  // also blocks the write so nothing lands in the array during reset.
  assign wr_acc = rst_n && wr_en && !full;
  assign rd_acc = rst_n && rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdat  (data_in),
    .re    (rd_acc),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdat  (data_out)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Purpose: directed self-checking bench for fifo_sync at default sizing (8 x 32).
// Latency: inputs change 1 time unit after each rising edge; outputs sampled there too.
// Backpressure: exercises dropped writes at full and ignored reads at empty.
module tb_fifo_sync;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_cmp;
  int n_mis;

  fifo_sync dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    data_in = 8'h77;
    rd_en   = 1'b0;

    // Reset for two edges with a write request pending.
    step();
    step();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_dout", {24'd0, data_out}, 32'h00);
    rst_n = 1'b1;
    wr_en = 1'b0;
    step();
    chk("rst_nowrite_empty", {31'd0, empty}, 32'd1);

    // Fill with 00..1F.
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(i);
      step();
      chk($sformatf("fill_empty_%0d", i), {31'd0, empty}, 32'd0);
      chk($sformatf("fill_full_%0d", i), {31'd0, full}, (i == 31) ? 32'd1 : 32'd0);
    end
    // 33rd write is dropped.
    data_in = 8'hAA;
    step();
    chk("drop_full", {31'd0, full}, 32'd1);
    wr_en = 1'b0;

    // Drain, expecting 00..1F in order.
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      step();
      chk($sformatf("drain_dout_%0d", i), {24'd0, data_out}, 32'(i));
      chk($sformatf("drain_full_%0d", i), {31'd0, full}, 32'd0);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Reads while empty: data_out holds 1F.
    step();
    step();
    chk("rdempty_dout", {24'd0, data_out}, 32'h1F);
    chk("rdempty_empty", {31'd0, empty}, 32'd1);
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    data_in = 8'h11;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rdempty_ptr_dout", {24'd0, data_out}, 32'h11);
    chk("rdempty_ptr_empty", {31'd0, empty}, 32'd1);

    // Simultaneous request at full.
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(8'h80 + i);
      step();
    end
    chk("simfull_pre_full", {31'd0, full}, 32'd1);
    rd_en   = 1'b1;
    data_in = 8'h55;
    step();
    chk("simfull_dout", {24'd0, data_out}, 32'h80);
    chk("simfull_full", {31'd0, full}, 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      step();
      chk($sformatf("simfull_drain_%0d", i), {24'd0, data_out}, 32'(8'h80 + i));
    end
    chk("simfull_55_not_stored", {31'd0, empty}, 32'd1);

    // Simultaneous request at empty.
    wr_en   = 1'b1;
    data_in = 8'h55;
    step();
    chk("simempty_dout", {24'd0, data_out}, 32'h9F);
    chk("simempty_empty", {31'd0, empty}, 32'd0);
    wr_en = 1'b0;
    step();
    chk("simempty_read", {24'd0, data_out}, 32'h55);
    chk("simempty_after", {31'd0, empty}, 32'd1);
    rd_en = 1'b0;

    // Prime 3 words, then stream 100 cycles of read+write across the wrap.
    for (int k = 0; k < 3; k++) begin
      wr_en   = 1'b1;
      data_in = 8'(k);
      step();
    end
    rd_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      data_in = 8'(c + 3);
      step();
      chk($sformatf("stream_dout_%0d", c), {24'd0, data_out}, 32'(c));
      chk($sformatf("stream_full_%0d", c), {31'd0, full}, 32'd0);
      chk($sformatf("stream_empty_%0d", c), {31'd0, empty}, 32'd0);
    end
    rd_en = 1'b0;

    // Bring occupancy to 10, then reset for one edge.
    for (int k = 0; k < 7; k++) begin
      data_in = 8'(8'hA0 + k);
      step();
    end
    wr_en = 1'b0;
    chk("midrst_pre_empty", {31'd0, empty}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_full", {31'd0, full}, 32'd0);
    chk("midrst_dout", {24'd0, data_out}, 32'h00);
    wr_en   = 1'b1;
    data_in = 8'h3C;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("midrst_read", {24'd0, data_out}, 32'h3C);
    chk("midrst_read_empty", {31'd0, empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
